// File: rtl/tetris_link_pkg.sv
// Shared constants and state encoding for the byte-wide grid link.
package tetris_link_pkg;
  localparam int GRID_W      = 256;
  localparam int LINK_BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } link_rx_state_t;
endpackage

// File: rtl/link_sync.sv
// Two-flop synchronizer for an asynchronous link pin, with rise detection
// against a third flop.
module link_sync (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic rise
);
  logic [2:0] sync_sr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) sync_sr <= 3'b000;
    else       sync_sr <= {sync_sr[1:0], din};
  end

  assign rise = sync_sr[1] & ~sync_sr[2];
endmodule

// File: rtl/grid_link_receiver.sv
// Receive end of the byte-wide grid link: start marker plus FRAME_BYTES strobed
// bytes are reassembled into the packed grid word.
module grid_link_receiver
  import tetris_link_pkg::*;
#(
  parameter int FRAME_BYTES = 32,
  parameter int TIMEOUT     = 4096
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               link_start,
  input  logic                               link_strobe,
  input  logic [LINK_BYTE_W-1:0]             link_data,
  output logic [LINK_BYTE_W*FRAME_BYTES-1:0] grid_out,
  output logic                               frame_valid,
  output logic                               frame_error,
  output logic                               busy,
  output logic [5:0]                         byte_count
);
  localparam int GW = LINK_BYTE_W * FRAME_BYTES;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [5:0]    LAST_BYTE = 6'(FRAME_BYTES - 1);
  localparam logic [TW-1:0] IDLE_LIM  = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] IDLE_ONE  = TW'(1);

  link_rx_state_t state, state_nx;
  logic                   start_rise, strobe_rise;
  logic [LINK_BYTE_W-1:0] data_s1, data_s2;
  logic [GW-1:0]          frame_buf;
  logic [5:0]             count_nx;
  logic [TW-1:0]          idle_cnt, idle_nx;
  logic                   clear_buf, capture, load_grid, valid_nx, error_nx;

  link_sync u_start_sync  (.clock(clock), .reset(reset), .din(link_start),  .rise(start_rise));
  link_sync u_strobe_sync (.clock(clock), .reset(reset), .din(link_strobe), .rise(strobe_rise));

  // Data lane goes through the same two stages so it lines up with the strobe rise.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_s1 <= '0;
      data_s2 <= '0;
    end else begin
      data_s1 <= link_data;
      data_s2 <= data_s1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // A start rise mid-frame outranks a simultaneous strobe, so that byte is dropped.
  always_comb begin
    state_nx  = state;
    count_nx  = byte_count;
    idle_nx   = idle_cnt;
    clear_buf = 1'b0;
    capture   = 1'b0;
    load_grid = 1'b0;
    valid_nx  = 1'b0;
    error_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (start_rise) begin
          state_nx  = RECV;
          count_nx  = 6'd0;
          idle_nx   = '0;
          clear_buf = 1'b1;
        end
      end
      RECV: begin
        if (start_rise) begin
          error_nx  = 1'b1;
          count_nx  = 6'd0;
          idle_nx   = '0;
          clear_buf = 1'b1;
        end else if (strobe_rise) begin
          capture = 1'b1;
          idle_nx = '0;
          if (byte_count == LAST_BYTE) begin
            count_nx = 6'd0;
            state_nx = DONE;
          end else begin
            count_nx = byte_count + 6'd1;
          end
        end else if (idle_cnt == IDLE_LIM) begin
          error_nx = 1'b1;
          state_nx = IDLE;
          count_nx = 6'd0;
          idle_nx  = '0;
        end else begin
          idle_nx = idle_cnt + IDLE_ONE;
        end
      end
      DONE: begin
        load_grid = 1'b1;
        valid_nx  = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frame_buf   <= '0;
      grid_out    <= '0;
      byte_count  <= 6'd0;
      idle_cnt    <= '0;
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      if (clear_buf)    frame_buf <= '0;
      else if (capture) frame_buf[LINK_BYTE_W*byte_count +: LINK_BYTE_W] <= data_s2;
      if (load_grid)    grid_out <= frame_buf;
      byte_count  <= count_nx;
      idle_cnt    <= idle_nx;
      frame_valid <= valid_nx;
      frame_error <= error_nx;
    end
  end

  assign busy = (state == RECV);
endmodule
